// File: rtl/eca_pkg.sv
// rtl/eca_pkg.sv - shared types and constants for the elementary cellular automaton engine
package eca_pkg;

    localparam int OUT_W = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EMIT = 2'd1,
        STEP = 2'd2
    } state_t;

endpackage

// File: rtl/eca_if.sv
// rtl/eca_if.sv - seed-load and word-stream handshake bundle for eca_engine
interface eca_if;
    import eca_pkg::*;

    logic             load_valid;
    logic [7:0]       load_data;
    logic             load_ready;

    logic             out_valid;
    logic [OUT_W-1:0] out_data;
    logic             out_ready;
    logic             out_last;
    logic [7:0]       out_gen;

    modport master (
        output load_valid, load_data, out_ready,
        input  load_ready, out_valid, out_data, out_last, out_gen
    );

    modport slave (
        input  load_valid, load_data, out_ready,
        output load_ready, out_valid, out_data, out_last, out_gen
    );

endinterface

// File: rtl/eca_step.sv
// rtl/eca_step.sv - combinational next-generation evaluation of the cell array
module eca_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] cells,
    input  logic [7:0]       rule,
    input  logic             wrap,
    output logic [WIDTH-1:0] next_cells
);

    // left[i] is cell[i+1] and right[i] is cell[i-1]; the ends either wrap or see a zero
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;

    assign left  = {wrap & cells[0], cells[WIDTH-1:1]};
    assign right = {cells[WIDTH-2:0], wrap & cells[WIDTH-1]};

    for (genvar i = 0; i < WIDTH; i++) begin : g_cell
        assign next_cells[i] = rule[{left[i], cells[i], right[i]}];
    end

endmodule

// File: rtl/eca_engine.sv
// rtl/eca_engine.sv - byte-loaded elementary cellular automaton streaming 16-bit words per generation
module eca_engine
    import eca_pkg::*;
#(
    parameter int WIDTH = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rule,
    input  logic       wrap,
    input  logic [7:0] gens,
    input  logic       start,
    output logic       busy,
    output logic       done,
    eca_if.slave       bus
);

    localparam int NW = WIDTH / OUT_W;
    localparam int IW = (NW > 1) ? $clog2(NW) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(NW - 1);

    if ((WIDTH % OUT_W) != 0 || WIDTH < OUT_W) begin : g_bad_width
        $error("eca_engine: WIDTH must be a multiple of 16 and at least 16");
    end

    state_t           state;
    logic [WIDTH-1:0] cells;
    logic [WIDTH-1:0] next_cells;
    logic [IW-1:0]    word_idx;
    logic [7:0]       out_gen_q;
    logic [7:0]       rule_q;
    logic             wrap_q;
    logic [7:0]       gens_q;
    logic             out_valid_q;
    logic             load_ready_q;
    logic             busy_q;
    logic             done_q;

    // Word k of the frame is taken from the most significant end downward
    logic [OUT_W-1:0] words [NW];
    for (genvar k = 0; k < NW; k++) begin : g_words
        assign words[k] = cells[WIDTH-1-OUT_W*k -: OUT_W];
    end

    eca_step #(.WIDTH(WIDTH)) u_step (
        .cells      (cells),
        .rule       (rule_q),
        .wrap       (wrap_q),
        .next_cells (next_cells)
    );

    // Stream outputs derive only from registers, so they hold while the sink stalls
    assign bus.out_valid  = out_valid_q;
    assign bus.out_data   = out_valid_q ? words[word_idx] : '0;
    assign bus.out_last   = out_valid_q && (word_idx == LAST_IDX);
    assign bus.out_gen    = out_gen_q;
    assign bus.load_ready = load_ready_q;
    assign busy           = busy_q;
    assign done           = done_q;

    // Control FSM: seed loading and run launch in IDLE, frame streaming in EMIT, one update in STEP
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cells        <= '0;
            word_idx     <= '0;
            out_gen_q    <= '0;
            rule_q       <= '0;
            wrap_q       <= 1'b0;
            gens_q       <= '0;
            out_valid_q  <= 1'b0;
            load_ready_q <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.load_valid) begin
                        // a load always beats a simultaneous start
                        cells <= {cells[WIDTH-9:0], bus.load_data};
                    end else if (start) begin
                        rule_q       <= rule;
                        wrap_q       <= wrap;
                        gens_q       <= gens;
                        out_gen_q    <= '0;
                        word_idx     <= '0;
                        out_valid_q  <= 1'b1;
                        load_ready_q <= 1'b0;
                        busy_q       <= 1'b1;
                        state        <= EMIT;
                    end
                end
                EMIT: begin
                    if (bus.out_ready) begin
                        if (word_idx == LAST_IDX) begin
                            word_idx    <= '0;
                            out_valid_q <= 1'b0;
                            if (out_gen_q == gens_q) begin
                                load_ready_q <= 1'b1;
                                busy_q       <= 1'b0;
                                done_q       <= 1'b1;
                                state        <= IDLE;
                            end else begin
                                state <= STEP;
                            end
                        end else begin
                            word_idx <= word_idx + 1'b1;
                        end
                    end
                end
                STEP: begin
                    cells       <= next_cells;
                    out_gen_q   <= out_gen_q + 8'd1;
                    out_valid_q <= 1'b1;
                    state       <= EMIT;
                end
                default: begin
                    out_valid_q  <= 1'b0;
                    load_ready_q <= 1'b1;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_eca_engine.sv
// tb/tb_eca_engine.sv - directed self-checking bench for eca_engine at WIDTH=32
module tb_eca_engine;

    localparam int W = 32;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rule;
    logic       wrap;
    logic [7:0] gens;
    logic       start;
    logic       busy;
    logic       done;

    eca_if bus();

    eca_engine #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .rule  (rule),
        .wrap  (wrap),
        .gens  (gens),
        .start (start),
        .busy  (busy),
        .done  (done),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [15:0] got_data [$];
    logic [7:0]  got_gen  [$];
    bit          got_last [$];
    int          done_cnt;
    int          stall_viol;
    bit          timed_out;

    task automatic load_seed(input logic [31:0] seed);
        for (int b = 3; b >= 0; b--) begin
            bus.load_valid = 1'b1;
            bus.load_data  = seed[8*b +: 8];
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
    endtask

    task automatic do_start(input logic [7:0] r, input logic w, input logic [7:0] g);
        rule  = r;
        wrap  = w;
        gens  = g;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: always ready; mode 1: ready pattern 1,0,0,1 repeating
    task automatic collect(input int mode);
        logic        prev_stall;
        logic [15:0] pd;
        logic        pl;
        logic [7:0]  pg;
        int          tail;
        got_data.delete();
        got_gen.delete();
        got_last.delete();
        done_cnt   = 0;
        stall_viol = 0;
        timed_out  = 1'b1;
        prev_stall = 1'b0;
        pd = '0; pl = 1'b0; pg = '0;
        tail = -1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            logic rdy;
            rdy = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            if (prev_stall && (bus.out_valid !== 1'b1 || bus.out_data !== pd ||
                               bus.out_last !== pl || bus.out_gen !== pg))
                stall_viol++;
            bus.out_ready = rdy;
            if (bus.out_valid === 1'b1 && rdy) begin
                got_data.push_back(bus.out_data);
                got_gen.push_back(bus.out_gen);
                got_last.push_back(bus.out_last);
            end
            prev_stall = (bus.out_valid === 1'b1) && !rdy;
            pd = bus.out_data; pl = bus.out_last; pg = bus.out_gen;
            if (done === 1'b1) begin
                done_cnt++;
                if (tail < 0) tail = 3;
            end
            if (tail == 0) begin
                timed_out = 1'b0;
                break;
            end
            if (tail > 0) tail--;
            @(negedge clk);
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset out_valid: got %b want 0", bus.out_valid); end
        checks++; if (bus.out_data !== 16'h0) begin errors++; $display("FAIL reset out_data: got %h want 0000", bus.out_data); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset out_last: got %b want 0", bus.out_last); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset done: got %b want 0", done); end
        checks++; if (bus.out_gen !== 8'h0) begin errors++; $display("FAIL reset out_gen: got %h want 00", bus.out_gen); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset load_ready: got %b want 1", bus.load_ready); end
    endtask

    task automatic test_rule110(input int mode, input string name);
        logic [15:0] exp [8];
        exp = '{16'h0000, 16'h0001, 16'h0000, 16'h0003, 16'h0000, 16'h0007, 16'h0000, 16'h000D};
        load_seed(32'h0000_0001);
        do_start(8'd110, 1'b0, 8'd3);
        collect(mode);
        checks++; if (got_data.size() != 8) begin errors++; $display("FAIL %s count: got %0d want 8", name, got_data.size()); end
        for (int i = 0; i < 8 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp[i]) begin errors++; $display("FAIL %s word[%0d]: got %h want %h", name, i, got_data[i], exp[i]); end
            checks++; if (got_gen[i] !== 8'(i / 2)) begin errors++; $display("FAIL %s gen[%0d]: got %0d want %0d", name, i, got_gen[i], i / 2); end
            checks++; if (got_last[i] !== (i % 2 == 1)) begin errors++; $display("FAIL %s last[%0d]: got %b want %b", name, i, got_last[i], (i % 2 == 1)); end
        end
        checks++; if (done_cnt != 1 || timed_out) begin errors++; $display("FAIL %s done: got %0d pulses timeout=%b want 1", name, done_cnt, timed_out); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL %s stall stability: got %0d violations want 0", name, stall_viol); end
    endtask

    task automatic test_boundary();
        logic [15:0] exp_w [4];
        logic [15:0] exp_z [4];
        exp_w = '{16'h0000, 16'h0001, 16'h8000, 16'h0002};
        exp_z = '{16'h0000, 16'h0001, 16'h0000, 16'h0002};
        load_seed(32'h0000_0001);
        do_start(8'd90, 1'b1, 8'd1);
        collect(0);
        checks++; if (got_data.size() != 4) begin errors++; $display("FAIL rule90 wrap count: got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp_w[i]) begin errors++; $display("FAIL rule90 wrap word[%0d]: got %h want %h", i, got_data[i], exp_w[i]); end
        end
        load_seed(32'h0000_0001);
        do_start(8'd90, 1'b0, 8'd1);
        collect(0);
        checks++; if (got_data.size() != 4) begin errors++; $display("FAIL rule90 zero count: got %0d want 4", got_data.size()); end
        for (int i = 0; i < 4 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp_z[i]) begin errors++; $display("FAIL rule90 zero word[%0d]: got %h want %h", i, got_data[i], exp_z[i]); end
        end
    endtask

    task automatic test_extremes();
        logic [15:0] exp0 [6];
        logic [15:0] exp1 [6];
        logic [15:0] expp [2];
        exp0 = '{16'h0000, 16'h0001, 16'h0000, 16'h0000, 16'h0000, 16'h0000};
        exp1 = '{16'h0000, 16'h0001, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};
        expp = '{16'hFFFF, 16'hFFFF};
        load_seed(32'h0000_0001);
        do_start(8'd0, 1'b0, 8'd2);
        collect(0);
        checks++; if (got_data.size() != 6) begin errors++; $display("FAIL rule0 count: got %0d want 6", got_data.size()); end
        for (int i = 0; i < 6 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp0[i]) begin errors++; $display("FAIL rule0 word[%0d]: got %h want %h", i, got_data[i], exp0[i]); end
        end
        load_seed(32'h0000_0001);
        do_start(8'd255, 1'b0, 8'd2);
        collect(0);
        checks++; if (got_data.size() != 6) begin errors++; $display("FAIL rule255 count: got %0d want 6", got_data.size()); end
        for (int i = 0; i < 6 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp1[i]) begin errors++; $display("FAIL rule255 word[%0d]: got %h want %h", i, got_data[i], exp1[i]); end
        end
        // no reload: the array continues from the last generation, generation count restarts
        do_start(8'd204, 1'b0, 8'd0);
        collect(0);
        checks++; if (got_data.size() != 2) begin errors++; $display("FAIL persist count: got %0d want 2", got_data.size()); end
        for (int i = 0; i < 2 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== expp[i]) begin errors++; $display("FAIL persist word[%0d]: got %h want %h", i, got_data[i], expp[i]); end
            checks++; if (got_gen[i] !== 8'd0) begin errors++; $display("FAIL persist gen[%0d]: got %0d want 0", i, got_gen[i]); end
        end
    endtask

    task automatic test_start_with_load();
        logic [31:0] seed;
        logic [15:0] exp [2];
        seed = 32'h1234_5678;
        exp  = '{16'h1234, 16'h5678};
        rule = 8'd204; wrap = 1'b0; gens = 8'd0;
        for (int b = 3; b >= 0; b--) begin
            bus.load_valid = 1'b1;
            bus.load_data  = seed[8*b +: 8];
            start = (b == 0);
            @(negedge clk);
        end
        bus.load_valid = 1'b0;
        start = 1'b0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start+load busy: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL start+load out_valid: got %b want 0", bus.out_valid); end
        do_start(8'd204, 1'b0, 8'd0);
        collect(0);
        checks++; if (got_data.size() != 2) begin errors++; $display("FAIL start+load count: got %0d want 2", got_data.size()); end
        for (int i = 0; i < 2 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp[i]) begin errors++; $display("FAIL start+load word[%0d]: got %h want %h", i, got_data[i], exp[i]); end
        end
    endtask

    task automatic test_start_busy();
        logic [15:0] exp [8];
        exp = '{16'h0000, 16'h0001, 16'h0000, 16'h0003, 16'h0000, 16'h0007, 16'h0000, 16'h000D};
        load_seed(32'h0000_0001);
        do_start(8'd110, 1'b0, 8'd3);
        for (int c = 0; c < 3; c++) begin
            start = 1'b1; rule = 8'd0; wrap = 1'b1; gens = 8'd0;
            bus.load_valid = 1'b1; bus.load_data = 8'hFF;
            checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy-start busy[%0d]: got %b want 1", c, busy); end
            checks++; if (bus.load_ready !== 1'b0) begin errors++; $display("FAIL busy-start load_ready[%0d]: got %b want 0", c, bus.load_ready); end
            @(negedge clk);
        end
        start = 1'b0;
        bus.load_valid = 1'b0;
        collect(0);
        checks++; if (got_data.size() != 8) begin errors++; $display("FAIL busy-start count: got %0d want 8", got_data.size()); end
        for (int i = 0; i < 8 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp[i]) begin errors++; $display("FAIL busy-start word[%0d]: got %h want %h", i, got_data[i], exp[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy-start done: got %0d want 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy-start idle after: got %b want 0", busy); end
    endtask

    task automatic test_reset_mid();
        bit found;
        logic [15:0] exp [2];
        exp = '{16'h0000, 16'h0000};
        found = 1'b0;
        load_seed(32'h0000_0001);
        do_start(8'd110, 1'b0, 8'd3);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40; c++) begin
            if (bus.out_valid === 1'b1 && bus.out_gen === 8'd1) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++; if (!found) begin errors++; $display("FAIL reset-mid reach frame1: got none want frame 1"); end
        rst = 1'b1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset-mid out_valid: got %b want 0", bus.out_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset-mid busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset-mid done: got %b want 0", done); end
        rst = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (done !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset-mid quiet[%0d]: got done=%b valid=%b want 0 0", c, done, bus.out_valid); end
        end
        bus.out_ready = 1'b0;
        checks++; if (bus.load_ready !== 1'b1) begin errors++; $display("FAIL reset-mid load_ready: got %b want 1", bus.load_ready); end
        do_start(8'd110, 1'b0, 8'd0);
        collect(0);
        checks++; if (got_data.size() != 2) begin errors++; $display("FAIL reset-mid rerun count: got %0d want 2", got_data.size()); end
        for (int i = 0; i < 2 && i < got_data.size(); i++) begin
            checks++; if (got_data[i] !== exp[i]) begin errors++; $display("FAIL reset-mid rerun word[%0d]: got %h want %h", i, got_data[i], exp[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL reset-mid rerun done: got %0d want 1", done_cnt); end
    endtask

    initial begin
        rst            = 1'b1;
        rule           = 8'd0;
        wrap           = 1'b0;
        gens           = 8'd0;
        start          = 1'b0;
        bus.load_valid = 1'b0;
        bus.load_data  = 8'h00;
        bus.out_ready  = 1'b0;
        @(negedge clk);
        test_reset();
        test_rule110(0, "rule110");
        test_rule110(1, "rule110-stall");
        test_boundary();
        test_extremes();
        test_start_with_load();
        test_start_busy();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/eca_engine.md
ECA_ENGINE -- requirements
Module: eca_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 64, number of cells; multiple of 16, minimum 16.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port rule  input  8  Wolfram rule number, sampled at start.
REQ-005 SHALL have port wrap  input  1  boundary mode (1 circular, 0 zero-padded), sampled at start.
REQ-006 SHALL have port gens  input  8  number of generations to compute after the seed, sampled at start.
REQ-007 SHALL have ports load_valid  input  1, load_data  input  8, load_ready  output  1: byte-serial seed load.
REQ-008 SHALL have port start  input  1  single-cycle run request.
REQ-009 SHALL have ports out_valid  output  1, out_data  output  16, out_ready  input  1: word stream.
REQ-010 SHALL have ports out_last  output  1 (final word of a frame), out_gen  output  8 (generation index of the current frame).
REQ-011 SHALL have ports busy  output  1 and done  output  1 (one-cycle pulse at run end).

Function
REQ-012 SHALL implement states IDLE, EMIT, STEP.
REQ-013 IDLE: load_ready=1; load handshake shifts cells <= {cells[WIDTH-9:0], load_data}; WIDTH/8 bytes fill the array, most significant byte first.
REQ-014 IDLE: start=1 with load_valid=0 latches rule/wrap/gens, clears out_gen to 0, enters EMIT; start in the same cycle as load_valid=1 is ignored (load wins).
REQ-015 EMIT: out_valid=1; word k (k=0..WIDTH/16-1) = cells[WIDTH-1-16k -: 16]; k advances only on out_valid&out_ready; out_last=1 when k=WIDTH/16-1.
REQ-016 EMIT, last word accepted: if out_gen==gens_latched go IDLE with done=1 that next cycle; else go STEP.
REQ-017 STEP: one cycle; new[i] = rule[{L,C,R}], L=cell[i+1], C=cell[i], R=cell[i-1]; out_gen increments; then EMIT.
REQ-018 Boundary: wrap=1 uses cell[0] as L of cell[WIDTH-1] and cell[WIDTH-1] as R of cell[0]; wrap=0 uses 0 for both.
REQ-019 Run with gens=G emits exactly G+1 frames (generation 0 is the seed); G=0 emits the seed only.
REQ-020 out_data, out_last, out_gen SHALL hold stable while out_valid=1 and out_ready=0.
REQ-021 busy=1 in EMIT and STEP; load_ready=0 and start ignored while busy.
REQ-022 Changes to rule/wrap/gens while busy SHALL not affect the current run.
REQ-023 Cell array SHALL persist after a run; a new start without reload continues from the last generation, out_gen restarting at 0.

Reset
REQ-024 rst=1 SHALL force IDLE, clear cells, word index, out_gen and latched rule/wrap/gens to 0 on the next edge, regardless of state.
REQ-025 During and after reset: out_valid=0, out_data=0, out_last=0, busy=0, done=0, load_ready=1 once in IDLE.
REQ-026 Reset mid-EMIT or mid-STEP SHALL abort the run with no done pulse and no further words.

Structure
REQ-027 Package eca_pkg SHALL hold the state enum (IDLE, EMIT, STEP) and constant OUT_W=16.
REQ-028 Next-generation logic SHALL be a combinational sub-module eca_step (parameter WIDTH; inputs cells, rule, wrap; output next cells).
REQ-029 Word-select index and generation counter SHALL be sized from WIDTH/16 and 8 bits respectively; no wrap-around of out_gen occurs since gens is 8 bits.

Verification
REQ-030 WIDTH=32, load 0x00,0x00,0x00,0x01, rule=110, wrap=0, gens=3, out_ready=1 -> words 0000 0001, 0000 0003, 0000 0007, 0000 000D; out_gen 0..3; out_last on every second word; done once.
REQ-031 WIDTH=32, seed 0x00000001, rule=90, wrap=1, gens=1 -> frames 0x00000001, 0x80000002; with wrap=0 -> 0x00000001, 0x00000002.
REQ-032 Rule=110 run with out_ready toggling 1,0,0,1 -> no word lost or duplicated, out_data stable while stalled, same sequence as REQ-030.
REQ-033 start asserted together with load_valid in IDLE -> byte loaded, no run; start while busy -> ignored, run count unchanged.
REQ-034 rst asserted during second frame of a gens=3 run -> next cycle out_valid=0, busy=0, no done; subsequent start with gens=0 emits 0x0000 0x0000.
REQ-035 rule=0, gens=2 -> frames seed, 0x00000000, 0x00000000; rule=255 -> seed, 0xFFFFFFFF, 0xFFFFFFFF.
